// File: rtl/m_turn_sequencer_pkg.sv
// Shared board geometry, state/winner encodings and the board helper functions
// (column legality, stone piling, four-in-a-row detection) for m_turn_sequencer.
package m_turn_sequencer_pkg;

   localparam int NUM_COLS               = 7;
   localparam int NUM_ROWS               = 6;
   localparam int FIELD_SIZE             = 42;   // bit index = row*7 + col, row 0 at the bottom
   localparam int COL_SIZE               = 3;
   localparam int PILED_COUNT_ARRAY_SIZE = 21;   // 3-bit height per column
   localparam int TIMEOUT_CNT_W          = 21;

   typedef logic [FIELD_SIZE-1:0]             field_t;
   typedef logic [PILED_COUNT_ARRAY_SIZE-1:0] piled_t;
   typedef logic [COL_SIZE-1:0]               col_t;

   typedef enum logic [1:0] {
      WIN_NONE  = 2'b00,
      WIN_AI    = 2'b01,
      WIN_HUMAN = 2'b10,
      WIN_DRAW  = 2'b11
   } winner_e;

   typedef enum logic [3:0] {
      S_IDLE,
      S_CLEAR,
      S_HUMAN_WAIT,
      S_HUMAN_APPLY,
      S_CHECK_H,
      S_AI_SEARCH,
      S_AI_APPLY,
      S_CHECK_A,
      S_GAME_OVER
   } state_e;

   typedef struct packed {
      field_t field;
      piled_t piled;
   } pile_t;

   // A column is open when it exists and still has room for a stone.
   function automatic logic f_col_open(input piled_t piled, input col_t col);
      logic open;
      open = 1'b0;
      for (int c = 0; c < NUM_COLS; c++) begin
         if (col == COL_SIZE'(c) && piled[c*COL_SIZE +: COL_SIZE] < COL_SIZE'(NUM_ROWS)) begin
            open = 1'b1;
         end
      end
      return open;
   endfunction

   // Drop one stone into col; a full column leaves field and heights untouched.
   function automatic pile_t f_pile(input field_t field, input piled_t piled, input col_t col);
      pile_t res;
      res.field = field;
      res.piled = piled;
      for (int c = 0; c < NUM_COLS; c++) begin
         if (col == COL_SIZE'(c)) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
               if (piled[c*COL_SIZE +: COL_SIZE] == COL_SIZE'(r)) begin
                  res.field[r*NUM_COLS + c]         = 1'b1;
                  res.piled[c*COL_SIZE +: COL_SIZE] = COL_SIZE'(r + 1);
               end
            end
         end
      end
      return res;
   endfunction

   // Four in a row: horizontal, vertical and both diagonals.
   function automatic logic f_four(input field_t f);
      logic hit;
      hit = 1'b0;
      for (int r = 0; r < NUM_ROWS; r++) begin
         for (int c = 0; c <= NUM_COLS - 4; c++) begin
            hit |= f[r*NUM_COLS + c] & f[r*NUM_COLS + c + 1]
                 & f[r*NUM_COLS + c + 2] & f[r*NUM_COLS + c + 3];
         end
      end
      for (int r = 0; r <= NUM_ROWS - 4; r++) begin
         for (int c = 0; c < NUM_COLS; c++) begin
            hit |= f[r*NUM_COLS + c] & f[(r+1)*NUM_COLS + c]
                 & f[(r+2)*NUM_COLS + c] & f[(r+3)*NUM_COLS + c];
         end
         for (int c = 0; c <= NUM_COLS - 4; c++) begin
            hit |= f[r*NUM_COLS + c] & f[(r+1)*NUM_COLS + c + 1]
                 & f[(r+2)*NUM_COLS + c + 2] & f[(r+3)*NUM_COLS + c + 3];
         end
         for (int c = 3; c < NUM_COLS; c++) begin
            hit |= f[r*NUM_COLS + c] & f[(r+1)*NUM_COLS + c - 1]
                 & f[(r+2)*NUM_COLS + c - 2] & f[(r+3)*NUM_COLS + c - 3];
         end
      end
      return hit;
   endfunction

endpackage

// File: rtl/m_turn_sequencer_fallback_col.sv
// Combinational picker: lowest-index column whose height is below NUM_ROWS.
// Used when the search result is invalid or names an unusable column.
module m_turn_sequencer_fallback_col
   import m_turn_sequencer_pkg::*;
(
   input  logic [PILED_COUNT_ARRAY_SIZE-1:0] i_piled_array,
   output logic [COL_SIZE-1:0]               o_col
);

   always_comb begin
      // NOTE: output defaulted before the loop so every path assigns it and no latch is inferred.
      o_col = '0;
      for (int c = NUM_COLS - 1; c >= 0; c--) begin
         if (i_piled_array[c*COL_SIZE +: COL_SIZE] < COL_SIZE'(NUM_ROWS)) begin
            o_col = COL_SIZE'(c);
         end
      end
   end

endmodule

// File: rtl/m_turn_sequencer.sv
// Match controller upstream of m_game_tree: owns the board, applies both sides' moves, declares the result.
// Optional search watchdog enabled by defining TURN_SEARCH_TIMEOUT_EN.
module m_turn_sequencer
   import m_turn_sequencer_pkg::*;
#(
   parameter bit          AI_FIRST       = 1'b0,
   parameter int unsigned SEARCH_TIMEOUT = 1048576
) (
   input  logic                              w_clk,
   input  logic                              w_rst,
   input  logic                              i_start,
   input  logic                              i_move_valid,
   input  logic [COL_SIZE-1:0]               i_move_col,
   input  logic                              i_tree_valid,
   input  logic                              i_tree_finished,
   input  logic [COL_SIZE-1:0]               i_tree_col,
   output logic                              o_tree_en,
   output logic [FIELD_SIZE-1:0]             o_me_field,
   output logic [FIELD_SIZE-1:0]             o_op_field,
   output logic [PILED_COUNT_ARRAY_SIZE-1:0] o_piled_array,
   output logic                              o_human_turn,
   output logic                              o_reject,
   output logic [1:0]                        o_winner,
   output logic [COL_SIZE-1:0]               o_last_col
);

   state_e  r_state;
   field_t  r_me_field;
   field_t  r_op_field;
   piled_t  r_piled;
   col_t    r_col;
   logic    r_tree_valid;
   logic    r_tree_en;
   logic    r_human_turn;
   logic    r_reject;
   winner_e r_winner;
   col_t    r_last_col;

   logic    w_ai_side;
   logic    w_move_ok;
   logic    w_ai_col_ok;
   col_t    w_fb_col;
   col_t    w_pile_col;
   field_t  w_pile_field_in;
   pile_t   w_pile;
   logic    w_me_four;
   logic    w_op_four;
   logic    w_board_full;
   logic    w_timeout;

   m_turn_sequencer_fallback_col u_fallback_col (
      .i_piled_array (r_piled),
      .o_col         (w_fb_col)
   );

   // One shared piler: the AI field in AI_APPLY, the human field otherwise.
   assign w_ai_side       = (r_state == S_AI_APPLY);
   assign w_move_ok       = f_col_open(r_piled, i_move_col);
   assign w_ai_col_ok     = r_tree_valid && f_col_open(r_piled, r_col);
   assign w_pile_col      = (w_ai_side && !w_ai_col_ok) ? w_fb_col : r_col;
   assign w_pile_field_in = w_ai_side ? r_me_field : r_op_field;
   assign w_pile          = f_pile(w_pile_field_in, r_piled, w_pile_col);

   assign w_me_four    = f_four(r_me_field);
   assign w_op_four    = f_four(r_op_field);
   assign w_board_full = &(r_me_field | r_op_field);

`ifdef TURN_SEARCH_TIMEOUT_EN
   localparam logic [TIMEOUT_CNT_W-1:0] TIMEOUT_LAST = TIMEOUT_CNT_W'(SEARCH_TIMEOUT - 1);

   logic [TIMEOUT_CNT_W-1:0] r_search_cnt;

   // Counts cycles spent in AI_SEARCH; zero on the first search cycle.
   always_ff @(posedge w_clk) begin
      if (w_rst || r_state != S_AI_SEARCH) begin
         r_search_cnt <= '0;
      end else begin
         r_search_cnt <= r_search_cnt + TIMEOUT_CNT_W'(1);
      end
   end

   assign w_timeout = (r_state == S_AI_SEARCH) && (r_search_cnt == TIMEOUT_LAST);
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge w_clk) begin
      if (w_rst) begin
         r_state      <= S_IDLE;
         r_me_field   <= '0;
         r_op_field   <= '0;
         r_piled      <= '0;
         r_col        <= '0;
         r_tree_valid <= 1'b0;
         r_tree_en    <= 1'b0;
         r_human_turn <= 1'b0;
         r_reject     <= 1'b0;
         r_winner     <= WIN_NONE;
         r_last_col   <= '0;
      end else begin
         // NOTE: non-blocking throughout, so every branch reads the pre-edge register values.
         r_reject <= 1'b0;
         case (r_state)
            S_IDLE, S_GAME_OVER: begin
               if (i_start) begin
                  r_winner <= WIN_NONE;
                  r_state  <= S_CLEAR;
               end
            end
            S_CLEAR: begin
               r_me_field <= '0;
               r_op_field <= '0;
               r_piled    <= '0;
               r_last_col <= '0;
               if (AI_FIRST) begin
                  r_tree_en <= 1'b1;
                  r_state   <= S_AI_SEARCH;
               end else begin
                  r_human_turn <= 1'b1;
                  r_state      <= S_HUMAN_WAIT;
               end
            end
            S_HUMAN_WAIT: begin
               if (i_move_valid) begin
                  if (w_move_ok) begin
                     r_col        <= i_move_col;
                     r_human_turn <= 1'b0;
                     r_state      <= S_HUMAN_APPLY;
                  end else begin
                     r_reject <= 1'b1;
                  end
               end
            end
            S_HUMAN_APPLY: begin
               r_op_field <= w_pile.field;
               r_piled    <= w_pile.piled;
               r_last_col <= w_pile_col;
               r_state    <= S_CHECK_H;
            end
            S_CHECK_H: begin
               if (w_op_four) begin
                  r_winner <= WIN_HUMAN;
                  r_state  <= S_GAME_OVER;
               end else if (w_board_full) begin
                  r_winner <= WIN_DRAW;
                  r_state  <= S_GAME_OVER;
               end else begin
                  r_tree_en <= 1'b1;
                  r_state   <= S_AI_SEARCH;
               end
            end
            S_AI_SEARCH: begin
               // A finished result wins over a coincident watchdog expiry.
               if (i_tree_finished || w_timeout) begin
                  r_tree_en    <= 1'b0;
                  r_col        <= i_tree_col;
                  r_tree_valid <= i_tree_finished && i_tree_valid;
                  r_state      <= S_AI_APPLY;
               end
            end
            S_AI_APPLY: begin
               r_me_field <= w_pile.field;
               r_piled    <= w_pile.piled;
               r_last_col <= w_pile_col;
               r_state    <= S_CHECK_A;
            end
            S_CHECK_A: begin
               if (w_me_four) begin
                  r_winner <= WIN_AI;
                  r_state  <= S_GAME_OVER;
               end else if (w_board_full) begin
                  r_winner <= WIN_DRAW;
                  r_state  <= S_GAME_OVER;
               end else begin
                  r_human_turn <= 1'b1;
                  r_state      <= S_HUMAN_WAIT;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_tree_en     = r_tree_en;
   assign o_me_field    = r_me_field;
   assign o_op_field    = r_op_field;
   assign o_piled_array = r_piled;
   assign o_human_turn  = r_human_turn;
   assign o_reject      = r_reject;
   assign o_winner      = r_winner;
   assign o_last_col    = r_last_col;

endmodule

// File: tb/tb_m_turn_sequencer.sv
// Self-checking bench for m_turn_sequencer: directed scenarios plus random games against a
// 2-D board model; a stub stands in for m_game_tree.
module tb_m_turn_sequencer;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        move_valid = 1'b0;
   logic [2:0]  move_col = 3'd0;
   logic        tree_valid = 1'b0;
   logic        tree_finished = 1'b0;
   logic [2:0]  tree_col = 3'd0;
   logic        tree_en;
   logic [41:0] me_field;
   logic [41:0] op_field;
   logic [20:0] piled;
   logic        human_turn;
   logic        reject;
   logic [1:0]  winner;
   logic [2:0]  last_col;

   int n_pass  = 0;
   int n_total = 0;

   // Model: board[row][col], 0 empty, 1 AI, 2 human (matches the winner code of each side).
   int board[6][7];
   int height[7];
   int stones;
   bit game_over;

   m_turn_sequencer #(.AI_FIRST(1'b0), .SEARCH_TIMEOUT(TO)) dut (
      .w_clk           (clk),
      .w_rst           (rst),
      .i_start         (start),
      .i_move_valid    (move_valid),
      .i_move_col      (move_col),
      .i_tree_valid    (tree_valid),
      .i_tree_finished (tree_finished),
      .i_tree_col      (tree_col),
      .o_tree_en       (tree_en),
      .o_me_field      (me_field),
      .o_op_field      (op_field),
      .o_piled_array   (piled),
      .o_human_turn    (human_turn),
      .o_reject        (reject),
      .o_winner        (winner),
      .o_last_col      (last_col)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic [41:0] exp_field(input int who);
      logic [41:0] f;
      f = '0;
      for (int r = 0; r < 6; r++)
         for (int c = 0; c < 7; c++)
            if (board[r][c] == who) f[r*7 + c] = 1'b1;
      return f;
   endfunction

   function automatic logic [20:0] exp_piled();
      logic [20:0] p;
      p = '0;
      for (int c = 0; c < 7; c++) p[c*3 +: 3] = 3'(height[c]);
      return p;
   endfunction

   function automatic bit model_wins(input int who);
      int dr[4];
      int dc[4];
      int rr;
      int cc;
      bit ok;
      dr = '{0, 1, 1, 1};
      dc = '{1, 0, 1, -1};
      for (int r = 0; r < 6; r++)
         for (int c = 0; c < 7; c++)
            for (int d = 0; d < 4; d++) begin
               ok = 1'b1;
               for (int k = 0; k < 4; k++) begin
                  rr = r + dr[d] * k;
                  cc = c + dc[d] * k;
                  if (rr < 0 || rr > 5 || cc < 0 || cc > 6) ok = 1'b0;
                  else if (board[rr][cc] != who) ok = 1'b0;
               end
               if (ok) return 1'b1;
            end
      return 1'b0;
   endfunction

   function automatic bit col_open(input int col);
      if (col < 0 || col > 6) return 1'b0;
      return height[col] < 6;
   endfunction

   function automatic int lowest_open();
      for (int c = 0; c < 7; c++) if (height[c] < 6) return c;
      return 0;
   endfunction

   task automatic model_reset;
      for (int r = 0; r < 6; r++)
         for (int c = 0; c < 7; c++) board[r][c] = 0;
      for (int c = 0; c < 7; c++) height[c] = 0;
      stones    = 0;
      game_over = 1'b0;
   endtask

   task automatic model_drop(input int who, input int col);
      board[height[col]][col] = who;
      height[col]++;
      stones++;
   endtask

   task automatic check_board(input string tag);
      check({tag, "_me_field"}, me_field, exp_field(1));
      check({tag, "_op_field"}, op_field, exp_field(2));
      check({tag, "_piled"}, piled, exp_piled());
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_tree_en"}, tree_en, 0);
      check({tag, "_human_turn"}, human_turn, 0);
      check({tag, "_reject"}, reject, 0);
      check({tag, "_winner"}, winner, 0);
      check({tag, "_last_col"}, last_col, 0);
      check({tag, "_fields"}, {me_field, op_field}, 0);
      check({tag, "_piled"}, piled, 0);
   endtask

   // Called right after the CHECK_H / CHECK_A edge.
   task automatic check_outcome(input int who, input string tag);
      if (model_wins(who)) begin
         check({tag, "_win_code"}, winner, 64'(who));
         check({tag, "_win_tree_en"}, tree_en, 0);
         check({tag, "_win_human_turn"}, human_turn, 0);
         game_over = 1'b1;
      end else if (stones == 42) begin
         check({tag, "_draw_code"}, winner, 3);
         check({tag, "_draw_tree_en"}, tree_en, 0);
         game_over = 1'b1;
      end else if (who == 2) begin
         check({tag, "_search_start"}, tree_en, 1);
      end else begin
         check({tag, "_turn_back"}, human_turn, 1);
      end
   endtask

   task automatic do_start;
      start = 1'b1;
      tick;
      start = 1'b0;
      tick;
      model_reset();
      check("start_human_turn", human_turn, 1);
      check("start_tree_en", tree_en, 0);
      check("start_winner", winner, 0);
      check("start_last_col", last_col, 0);
      check_board("start");
   endtask

   task automatic human_move(input int col, output bit legal);
      check("move_ready", human_turn, 1);
      move_valid = 1'b1;
      move_col   = 3'(col);
      tick;
      move_valid = 1'b0;
      legal = col_open(col);
      if (!legal) begin
         check("reject_pulse", reject, 1);
         check("reject_stays_turn", human_turn, 1);
         tick;
         check("reject_one_cycle", reject, 0);
         check_board("reject");
      end else begin
         check("no_reject", reject, 0);
         tick;
         model_drop(2, col);
         check_board("human");
         check("human_last_col", last_col, 64'(col));
         tick;
         check_outcome(2, "human");
      end
   endtask

   // Stub tree: finishes after `delay` cycles, or never (timeout mode).
   task automatic ai_turn(input int col, input bit valid, input int delay, input bit timeout);
      bit stable;
      int waits;
      int eff;
      stable = 1'b1;
      waits  = timeout ? TO - 1 : delay;
      repeat (waits) begin
         tick;
         if (tree_en !== 1'b1 || me_field !== exp_field(1) || op_field !== exp_field(2)
             || piled !== exp_piled()) stable = 1'b0;
      end
      check("search_stable", stable, 1);
      if (!timeout) begin
         tree_finished = 1'b1;
         tree_valid    = valid;
         tree_col      = 3'(col);
      end
      tick;
      tree_finished = 1'b0;
      tree_valid    = 1'b0;
      check("en_drop", tree_en, 0);
      eff = lowest_open();
      if (!timeout && valid && col_open(col)) eff = col;
      tick;
      model_drop(1, eff);
      check_board("ai");
      check("ai_last_col", last_col, 64'(eff));
      tick;
      check_outcome(1, "ai");
   endtask

   initial begin
      bit legal;
      int hcol;
      int guard;

      model_reset();
      repeat (3) tick;
      check_all_zero("in_reset");
      rst = 1'b0;
      tick;
      check_all_zero("idle");
      do_start();

      // First exchange: AI answers in column 3 on top of the human stone.
      human_move(3, legal);
      ai_turn(3, 1'b1, 10, 1'b0);
      check("me_bit10", me_field[10], 1);
      check("height3", piled[11:9], 2);

      // Fill column 0, then illegal moves.
      human_move(0, legal);
      ai_turn(0, 1'b1, 2, 1'b0);
      human_move(0, legal);
      ai_turn(0, 1'b1, 1, 1'b0);
      human_move(0, legal);
      ai_turn(0, 1'b1, 0, 1'b0);
      check("col0_full", piled[2:0], 6);
      human_move(0, legal);
      check("col0_rejected", legal, 0);
      human_move(7, legal);
      check("col7_rejected", legal, 0);

      // Fallback: full column, then invalid result.
      human_move(5, legal);
      ai_turn(0, 1'b1, 3, 1'b0);
      check("fallback_full_col", me_field[1], 1);
      human_move(4, legal);
      ai_turn(2, 1'b0, 2, 1'b0);
      check("fallback_invalid", me_field[8], 1);

      // i_start during play is ignored.
      start = 1'b1;
      tick;
      start = 1'b0;
      tick;
      check("start_ignored_turn", human_turn, 1);
      check_board("start_ignored");

      // Reset in the middle of a search.
      human_move(1, legal);
      tick;
      tick;
      check("en_before_rst", tree_en, 1);
      rst = 1'b1;
      tick;
      check_all_zero("mid_search_rst");
      rst = 1'b0;
      tick;
      model_reset();
      do_start();

      // Human wins along the bottom row, AI stacks in column 6.
      human_move(0, legal);
      ai_turn(6, 1'b1, 4, 1'b0);
      human_move(1, legal);
      ai_turn(6, 1'b1, 7, 1'b0);
      human_move(2, legal);
      ai_turn(6, 1'b1, 0, 1'b0);
      human_move(3, legal);
      check("human_win", winner, 2);
      repeat (5) tick;
      check("over_tree_en", tree_en, 0);
      check("over_winner_held", winner, 2);
      move_valid = 1'b1;
      move_col   = 3'd4;
      tick;
      move_valid = 1'b0;
      tick;
      check("over_no_reject", reject, 0);
      check_board("over_frozen");
      do_start();

`ifdef TURN_SEARCH_TIMEOUT_EN
      human_move(3, legal);
      ai_turn(0, 1'b0, 0, 1'b1);
      check("timeout_fallback", me_field[0], 1);
      do_start();
`endif

      // Random games.
      for (int g = 0; g < 6; g++) begin
         guard = 0;
         while (!game_over && guard < 200) begin
            guard++;
            hcol = ($urandom_range(0, 9) == 0) ? 7 : int'($urandom_range(0, 6));
            human_move(hcol, legal);
            if (legal && !game_over)
               ai_turn(int'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                       int'($urandom_range(0, 12)), 1'b0);
         end
         check("random_game_ended", game_over, 1);
         do_start();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
